// File: rtl/cordic_wb_ctrl.sv
// Wishbone slave front-end for the cordic core: angle/start registers, done
// capture into a RESULT register, timeout watchdog and level interrupt.
//
// state | meaning
// IDLE  | no operation in flight, GO accepted
// START | one-cycle start pulse to the core, watchdog loaded
// WAIT  | waiting for done or watchdog expiry
module cordic_wb_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          TIMEOUT   = 256
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        cordic_start,
    output logic [15:0] cordic_angle,
    input  logic [15:0] cordic_exp,
    input  logic        cordic_done,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    localparam logic [15:0] CNT_LOAD = 16'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [15:0] cnt;
    logic [15:0] result;
    logic        irq_en, valid, overrun, tmo_err, start_rej;

    logic        req, wr, rd, busy;
    logic [7:0]  off;
    logic        go_wr, ctrl_wr, angle_wr, status_wr, result_rd;
    logic        done_cap, tmo_hit;
    logic [31:0] rdata;
    logic        unused_bits;

    assign off       = wbs_adr_i[7:0];
    assign req       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wbs_ack_o;
    assign wr        = req & wbs_we_i;
    assign rd        = req & ~wbs_we_i;
    assign busy      = (state != IDLE);
    assign ctrl_wr   = wr & (off == 8'h00) & wbs_sel_i[0];
    assign go_wr     = ctrl_wr & wbs_dat_i[0];
    assign angle_wr  = wr & (off == 8'h04) & ~busy;
    assign status_wr = wr & (off == 8'h0C) & wbs_sel_i[0];
    assign result_rd = rd & (off == 8'h08);
    assign done_cap  = (state == WAIT) & cordic_done;
    // Watchdog counts down from TIMEOUT-1 so expiry is a compare against zero.
    assign tmo_hit   = (state == WAIT) & ~cordic_done & (cnt == 16'd0);
    assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[31:16]};

    always_comb begin
        rdata = 32'h0;
        case (off)
            8'h00:   rdata = {30'h0, irq_en, 1'b0};
            8'h04:   rdata = {16'h0, cordic_angle};
            8'h08:   rdata = {16'h0, result};
            8'h0C:   rdata = {27'h0, start_rej, tmo_err, overrun, valid, busy};
            default: rdata = 32'h0;
        endcase
    end

    always_comb begin
        state_nx     = state;
        cordic_start = 1'b0;
        case (state)
            IDLE:    if (go_wr) state_nx = START;
            START: begin
                cordic_start = 1'b1;
                state_nx     = WAIT;
            end
            WAIT:    if (done_cap || tmo_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            cnt          <= 16'h0;
            result       <= 16'h0;
            irq_en       <= 1'b0;
            valid        <= 1'b0;
            overrun      <= 1'b0;
            tmo_err      <= 1'b0;
            start_rej    <= 1'b0;
            irq          <= 1'b0;
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= 32'h0;
            cordic_angle <= 16'h0;
        end else begin
            state     <= state_nx;
            wbs_ack_o <= req;
            wbs_dat_o <= rd ? rdata : 32'h0;

            if (state == START)
                cnt <= CNT_LOAD;
            else if (state == WAIT && cnt != 16'd0)
                cnt <= cnt - 16'd1;

            if (ctrl_wr)
                irq_en <= wbs_dat_i[1];

            if (angle_wr && wbs_sel_i[0])
                cordic_angle[7:0] <= wbs_dat_i[7:0];
            if (angle_wr && wbs_sel_i[1])
                cordic_angle[15:8] <= wbs_dat_i[15:8];

            if (done_cap)
                result <= cordic_exp;

            // A capture on the same edge as a RESULT read wins and is not an overrun.
            if (done_cap)
                valid <= 1'b1;
            else if (result_rd)
                valid <= 1'b0;

            if (done_cap && valid && !result_rd)
                overrun <= 1'b1;
            else if (status_wr && wbs_dat_i[2])
                overrun <= 1'b0;

            if (tmo_hit)
                tmo_err <= 1'b1;
            else if (status_wr && wbs_dat_i[3])
                tmo_err <= 1'b0;

            if (go_wr && busy)
                start_rej <= 1'b1;
            else if (status_wr && wbs_dat_i[4])
                start_rej <= 1'b0;

            irq <= irq_en & (valid | tmo_err);
        end
    end

endmodule

// File: tb/tb_cordic_wb_ctrl.sv
// Scoreboarded bench for cordic_wb_ctrl: reads push expected data, a monitor
// pops and compares on every ack; the core is modelled by a done/exp driver.
module tb_cordic_wb_ctrl;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_dat_i = 32'h0, wbs_adr_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        cordic_start;
    logic [15:0] cordic_angle;
    logic [15:0] cordic_exp = 16'h0;
    logic        cordic_done = 1'b0;
    logic        irq;

    localparam logic [31:0] BASE = 32'h3000_0000;

    always #5 clk = ~clk;

    cordic_wb_ctrl #(.BASE_ADDR(BASE), .TIMEOUT(256)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .cordic_start(cordic_start), .cordic_angle(cordic_angle),
        .cordic_exp(cordic_exp), .cordic_done(cordic_done), .irq(irq)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    bit          chk_q[$];
    string       name_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor: every ack consumes one scoreboard entry.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        bit          c;
        string       nm;
        if (wbs_ack_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ack: ack got 1 expected 0");
            end else begin
                e  = exp_q.pop_front();
                c  = chk_q.pop_front();
                nm = name_q.pop_front();
                if (c) check(nm, wbs_dat_o, e);
            end
        end
    end

    int start_cnt = 0, start_w = 0, start_wmax = 0;
    always @(negedge clk) begin
        if (cordic_start === 1'b1) begin
            start_w++;
            if (start_w == 1) start_cnt++;
            if (start_w > start_wmax) start_wmax = start_w;
        end else begin
            start_w = 0;
        end
    end

    task automatic xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input bit we, input logic [31:0] expv, input string nm);
        int k;
        exp_q.push_back(we ? 32'h0 : expv);
        chk_q.push_back(!we);
        name_q.push_back(nm);
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        wbs_we_i  = we;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (wbs_ack_o !== 1'b1 && k < 5);
        check({nm, "_ack_latency"}, k, 1);
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] dat);
        xfer(BASE | 32'(off), dat, 4'hF, 1'b1, 32'h0, $sformatf("wr%02h", off));
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] expv, input string nm);
        xfer(BASE | 32'(off), 32'h0, 4'hF, 1'b0, expv, nm);
    endtask

    // Core model: wait for the start pulse, then strobe done after dly cycles.
    task automatic do_done(input logic [15:0] e, input int dly);
        int k = 0;
        while (cordic_start !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("start_seen", {31'h0, cordic_start}, 32'h1);
        repeat (dly) @(negedge clk);
        cordic_exp  = e;
        cordic_done = 1'b1;
        @(negedge clk);
        cordic_done = 1'b0;
        cordic_exp  = 16'h0;
    endtask

    task automatic measure_timeout();
        int k = 0;
        while (cordic_start !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (irq !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        // Start cycle, 256 WAIT cycles, then TIMEOUT_ERR and one more for irq.
        check("timeout_irq_delay", k, 258);
    endtask

    task automatic no_ack_window(input logic [31:0] adr);
        int acks = 0;
        wbs_adr_i = adr;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (wbs_ack_o === 1'b1) acks++;
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        @(negedge clk);
        check($sformatf("no_ack_%h", adr), acks, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        wb_rst_i = 1'b0;
        @(negedge clk);

        check("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
        check("rst_dat", wbs_dat_o, 32'h0);
        check("rst_start", {31'h0, cordic_start}, 32'h0);
        check("rst_angle", {16'h0, cordic_angle}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rd(8'h00, 32'h0, "rst_ctrl");
        rd(8'h04, 32'h0, "rst_angle_rd");
        rd(8'h08, 32'h0, "rst_result");
        rd(8'h0C, 32'h0, "rst_status");
        check("rst_no_start", start_cnt, 0);

        // Normal operation with GO/ANGLE rejection during WAIT.
        wr(8'h04, 32'h0000_1234);
        check("angle_set", {16'h0, cordic_angle}, 32'h1234);
        fork
            do_done(16'hBEEF, 30);
            begin
                wr(8'h00, 32'h3);
                wr(8'h00, 32'h3);
                wr(8'h04, 32'h0000_0001);
                check("angle_locked", {16'h0, cordic_angle}, 32'h1234);
                rd(8'h0C, 32'h11, "status_busy_rej");
                wr(8'h0C, 32'h10);
                rd(8'h0C, 32'h01, "status_rej_cleared");
                check("irq_wait", {31'h0, irq}, 32'h0);
            end
        join
        repeat (2) @(negedge clk);
        check("irq_valid", {31'h0, irq}, 32'h1);
        check("one_start_op1", start_cnt, 1);
        rd(8'h0C, 32'h2, "status_valid");
        rd(8'h08, 32'hBEEF, "result_beef");
        rd(8'h0C, 32'h0, "status_after_rd");
        check("irq_cleared", {31'h0, irq}, 32'h0);

        // Watchdog expiry.
        fork
            wr(8'h00, 32'h3);
            measure_timeout();
        join
        rd(8'h0C, 32'h8, "status_timeout");
        rd(8'h08, 32'hBEEF, "result_kept");
        wr(8'h0C, 32'h8);
        rd(8'h0C, 32'h0, "status_tmo_cleared");
        check("irq_tmo_cleared", {31'h0, irq}, 32'h0);

        // Two results without reading: overrun.
        fork
            wr(8'h00, 32'h3);
            do_done(16'h0011, 5);
        join
        repeat (3) @(negedge clk);
        fork
            wr(8'h00, 32'h3);
            do_done(16'h0022, 5);
        join
        repeat (3) @(negedge clk);
        rd(8'h0C, 32'h6, "status_overrun");
        rd(8'h08, 32'h22, "result_22");
        rd(8'h0C, 32'h4, "status_ovr_sticky");
        wr(8'h0C, 32'h4);
        rd(8'h0C, 32'h0, "status_ovr_cleared");

        // Reset while in WAIT, then a late done must not be captured.
        wr(8'h00, 32'h3);
        repeat (4) @(negedge clk);
        wb_rst_i = 1'b1;
        @(negedge clk);
        wb_rst_i    = 1'b0;
        cordic_exp  = 16'h5555;
        cordic_done = 1'b1;
        @(negedge clk);
        cordic_done = 1'b0;
        cordic_exp  = 16'h0;
        repeat (2) @(negedge clk);
        rd(8'h0C, 32'h0, "status_post_rst");
        rd(8'h08, 32'h0, "result_post_rst");
        rd(8'h04, 32'h0, "angle_post_rst");
        rd(8'h00, 32'h0, "ctrl_post_rst");
        check("irq_post_rst", {31'h0, irq}, 32'h0);

        // Byte lanes and sel[0] gating of GO.
        xfer(BASE | 32'h04, 32'h0000_ABCD, 4'b0010, 1'b1, 32'h0, "angle_hi");
        rd(8'h04, 32'hAB00, "angle_hi_only");
        xfer(BASE | 32'h04, 32'h0000_0077, 4'b0001, 1'b1, 32'h0, "angle_lo");
        rd(8'h04, 32'hAB77, "angle_lo_only");
        xfer(BASE | 32'h00, 32'h0000_0003, 4'b1110, 1'b1, 32'h0, "ctrl_nosel0");
        rd(8'h00, 32'h0, "ctrl_nosel0_rd");

        // Window decode and unmapped offsets.
        no_ack_window(32'h3000_0100);
        no_ack_window(32'h2FFF_FF0C);
        wr(8'h10, 32'hFFFF_FFFF);
        rd(8'h10, 32'h0, "unmapped_rd");
        rd(8'h0C, 32'h0, "status_final");

        repeat (3) @(negedge clk);
        check("total_starts", start_cnt, 5);
        check("start_width", start_wmax, 1);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
